// File: rtl/poly_frommsg_expand_pkg.sv
// -----------------------------------------------------------------------------
// poly_frommsg_expand_pkg
//   Shared Kyber parameters and FSM state encoding for the message expander.
//   Contents:
//     KYBER_N       polynomial length (multiple of 8)
//     KYBER_Q       modulus
//     KYBER_HALF_Q  (KYBER_Q+1)/2, the value a set message bit maps to
//     COEFF_W       coefficient width
//     state_t       IDLE / FETCH / EMIT / DONE, 2-bit encoding
// -----------------------------------------------------------------------------
package poly_frommsg_expand_pkg;

   localparam int KYBER_N      = 256;
   localparam int KYBER_Q      = 3329;
   localparam int KYBER_HALF_Q = (KYBER_Q + 1) / 2;
   localparam int COEFF_W      = 12;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EMIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Rounded half of the modulus; kept as a function so the masked variant
   // can derive the same constant from its own parameterisation.
   function automatic int half_q(input int q);
      return (q + 1) / 2;
   endfunction

endpackage

// File: rtl/poly_frommsg_bit2coeff.sv
// -----------------------------------------------------------------------------
// poly_frommsg_bit2coeff
//   Combinational mapping of one message bit to one polynomial coefficient:
//   bit=1 -> (KYBER_Q+1)/2, bit=0 -> 0. The result is always below KYBER_Q.
//   Ports:
//     bit_val  in   1        message bit
//     coeff    out  o_Width  expanded coefficient
// -----------------------------------------------------------------------------
module poly_frommsg_bit2coeff
   import poly_frommsg_expand_pkg::*;
#(
   parameter int KYBER_Q = poly_frommsg_expand_pkg::KYBER_Q,
   parameter int o_Width = poly_frommsg_expand_pkg::COEFF_W
) (
   input  logic               bit_val,
   output logic [o_Width-1:0] coeff
);

   localparam logic [o_Width-1:0] HALF_Q = o_Width'(half_q(KYBER_Q));

   assign coeff = bit_val ? HALF_Q : '0;

endmodule

// File: rtl/poly_frommsg_expand.sv
// -----------------------------------------------------------------------------
// poly_frommsg_expand
//   Expands a 32-byte Kyber message into the 256-coefficient polynomial used in
//   encryption. Bytes arrive over a valid/ready input; each byte is emitted LSB
//   first as eight coefficients over a valid/ready output.
//   Ports:
//     iClk         in   1        clock, rising edge
//     iRstN        in   1        asynchronous active-low reset
//     iStart       in   1        start pulse, honoured only in IDLE
//     iMsgByte     in   8        message byte (bit 0 -> lowest index)
//     iMsgValid    in   1        iMsgByte valid
//     oMsgReady    out  1        high only in FETCH
//     oPolyCoeffs  out  o_Width  expanded coefficient
//     oCoeffIdx    out  8        index of oPolyCoeffs
//     oCoeffValid  out  1        coefficient valid
//     iCoeffReady  in   1        downstream ready
//     oBusy        out  1        high in every state except IDLE
//     oDone        out  1        one-cycle pulse after the last transfer
// -----------------------------------------------------------------------------
module poly_frommsg_expand
   import poly_frommsg_expand_pkg::*;
#(
   parameter int KYBER_N = poly_frommsg_expand_pkg::KYBER_N,
   parameter int KYBER_Q = poly_frommsg_expand_pkg::KYBER_Q,
   parameter int o_Width = poly_frommsg_expand_pkg::COEFF_W
) (
   input  logic               iClk,
   input  logic               iRstN,
   input  logic               iStart,
   input  logic [7:0]         iMsgByte,
   input  logic               iMsgValid,
   output logic               oMsgReady,
   output logic [o_Width-1:0] oPolyCoeffs,
   output logic [7:0]         oCoeffIdx,
   output logic               oCoeffValid,
   input  logic               iCoeffReady,
   output logic               oBusy,
   output logic               oDone
);

   localparam logic [7:0] LAST_IDX = 8'(KYBER_N - 1);

   state_t             state;
   logic [7:0]         byte_reg;
   logic [2:0]         bitcnt;
   logic [7:0]         coef_cnt;

   logic               next_bit;
   logic [o_Width-1:0] next_coeff;
   logic               coeff_xfer;
   logic               last_bit;

   // The output coefficient is registered, so it is computed one step ahead:
   // from the incoming byte when leaving FETCH, otherwise from the next bit
   // of the held byte.
   always_comb begin
      // NOTE: assign a default first so no path through this block can leave
      // next_bit unassigned and infer a latch.
      next_bit = 1'b0;
      if (state == ST_FETCH) begin
         next_bit = iMsgByte[0];
      end else begin
         next_bit = byte_reg[bitcnt + 3'd1];
      end
   end

   poly_frommsg_bit2coeff #(
      .KYBER_Q (KYBER_Q),
      .o_Width (o_Width)
   ) u_bit2coeff (
      .bit_val (next_bit),
      .coeff   (next_coeff)
   );

   assign coeff_xfer = oCoeffValid && iCoeffReady;
   assign last_bit   = (bitcnt == 3'd7);

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   // NOTE: all registers here, byte_reg included, are small flops rather than a
   // memory, so each one gets an asynchronous reset value.
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         state       <= ST_IDLE;
         byte_reg    <= '0;
         bitcnt      <= '0;
         coef_cnt    <= '0;
         oMsgReady   <= 1'b0;
         oPolyCoeffs <= '0;
         oCoeffIdx   <= '0;
         oCoeffValid <= 1'b0;
         oBusy       <= 1'b0;
         oDone       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (iStart) begin
                  state     <= ST_FETCH;
                  coef_cnt  <= '0;
                  bitcnt    <= '0;
                  oMsgReady <= 1'b1;
                  oBusy     <= 1'b1;
               end
            end

            // oMsgReady is a register that is high exactly in this state, so
            // iMsgValid alone qualifies the handshake here.
            ST_FETCH: begin
               if (iMsgValid) begin
                  state       <= ST_EMIT;
                  byte_reg    <= iMsgByte;
                  bitcnt      <= '0;
                  oMsgReady   <= 1'b0;
                  oCoeffValid <= 1'b1;
                  oPolyCoeffs <= next_coeff;
                  oCoeffIdx   <= coef_cnt;
               end
            end

            // Without a transfer nothing changes, which gives the stall hold.
            ST_EMIT: begin
               if (coeff_xfer) begin
                  bitcnt   <= bitcnt + 3'd1;
                  // On the final transfer this wraps to 0, ready for the next
                  // pass; it is cleared again on start regardless.
                  coef_cnt <= coef_cnt + 8'd1;
                  if (last_bit) begin
                     oCoeffValid <= 1'b0;
                     oPolyCoeffs <= '0;
                     oCoeffIdx   <= '0;
                     if (coef_cnt == LAST_IDX) begin
                        state <= ST_DONE;
                        oDone <= 1'b1;
                     end else begin
                        state     <= ST_FETCH;
                        oMsgReady <= 1'b1;
                     end
                  end else begin
                     oPolyCoeffs <= next_coeff;
                     oCoeffIdx   <= coef_cnt + 8'd1;
                  end
               end
            end

            ST_DONE: begin
               state <= ST_IDLE;
               oDone <= 1'b0;
               oBusy <= 1'b0;
            end

            default: begin
               state       <= ST_IDLE;
               oMsgReady   <= 1'b0;
               oCoeffValid <= 1'b0;
               oBusy       <= 1'b0;
               oDone       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_poly_frommsg_expand.sv
module tb_poly_frommsg_expand;

   localparam int N      = 256;
   localparam int Q      = 3329;
   localparam int NBYTES = N / 8;

   logic        iClk = 1'b0;
   logic        iRstN;
   logic        iStart;
   logic [7:0]  iMsgByte;
   logic        iMsgValid;
   logic        oMsgReady;
   logic [11:0] oPolyCoeffs;
   logic [7:0]  oCoeffIdx;
   logic        oCoeffValid;
   logic        iCoeffReady;
   logic        oBusy;
   logic        oDone;

   poly_frommsg_expand dut (
      .iClk        (iClk),
      .iRstN       (iRstN),
      .iStart      (iStart),
      .iMsgByte    (iMsgByte),
      .iMsgValid   (iMsgValid),
      .oMsgReady   (oMsgReady),
      .oPolyCoeffs (oPolyCoeffs),
      .oCoeffIdx   (oCoeffIdx),
      .oCoeffValid (oCoeffValid),
      .iCoeffReady (iCoeffReady),
      .oBusy       (oBusy),
      .oDone       (oDone)
   );

   always #5 iClk = ~iClk;

   int checks = 0;
   int errors = 0;

   logic [7:0]  msg [NBYTES];
   logic [11:0] cap [N];

   typedef struct {
      string      name;
      bit         rand_msg;
      logic [7:0] fill;
      logic [7:0] b0;
      int         vpct;
      int         rpct;
      bit         noise;
      int         exp_cyc;
   } scen_t;

   typedef struct {
      int          idx;
      logic [11:0] coeff;
   } vec_t;

   scen_t scen [5];
   vec_t  vecs [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: coefficient k is (Q+1)/2 when message bit k is set, else 0.
   function automatic logic [11:0] ref_coeff(input int k);
      logic [7:0] b;
      if (k < 0 || k >= N) return 12'hfff;
      b = msg[k / 8];
      return b[k % 8] ? 12'((Q + 1) / 2) : 12'd0;
   endfunction

   task automatic check_all_zero(input string name);
      check(name, {8'd0, oMsgReady, oCoeffValid, oBusy, oDone, oCoeffIdx, oPolyCoeffs}, 32'd0);
   endtask

   // One full pass: start, feed the message with random valid gaps, drain the
   // coefficients with random ready gaps, and score against the reference.
   task automatic run_pass(input string tag, input int vpct, input int rpct,
                           input bit noise, input int abort_idx, input int exp_cyc);
      int xfers, nbytes, done_cnt, done_cyc, pending;
      logic pv, pr;
      logic [11:0] pc;
      logic [7:0]  pi;
      xfers = 0; nbytes = 0; done_cnt = 0; done_cyc = -1;
      pv = 1'b0; pr = 1'b0; pc = '0; pi = '0;
      @(negedge iClk);
      iStart = 1'b1; iMsgValid = 1'b0; iCoeffReady = 1'b0;
      for (int cyc = 1; cyc < 20000; cyc++) begin
         @(negedge iClk);
         if (abort_idx >= 0 && oCoeffValid && oCoeffIdx == 8'(abort_idx)) begin
            iRstN = 1'b0;
            #1;
            check_all_zero({tag, "_abort_outputs"});
            for (int k = 0; k < 3; k++) begin
               @(negedge iClk);
               if (oDone) done_cnt++;
            end
            check({tag, "_abort_no_done"}, done_cnt, 0);
            check_all_zero({tag, "_abort_held"});
            iStart = 1'b0; iMsgValid = 1'b0; iCoeffReady = 1'b0;
            iRstN = 1'b1;
            return;
         end
         pending = nbytes * 8 - xfers;
         if (pv && !pr)
            check({tag, "_stall_hold"}, {11'd0, oCoeffValid, oCoeffIdx, oPolyCoeffs},
                  {11'd0, 1'b1, pi, pc});
         if (oMsgReady) check({tag, "_ready_only_fetch"}, pending, 0);
         if (oCoeffValid) check({tag, "_valid_has_data"}, 32'(pending > 0), 1);
         if (oDone) begin
            if (done_cnt == 0) done_cyc = cyc;
            done_cnt++;
         end
         if (done_cnt > 0 && cyc >= done_cyc + 3) break;
         iStart      = noise && oBusy && ($urandom_range(0, 3) == 0);
         iMsgValid   = noise ? 1'b1 : ($urandom_range(0, 99) < vpct);
         iMsgByte    = (nbytes < NBYTES) ? msg[nbytes] : 8'($urandom);
         iCoeffReady = ($urandom_range(0, 99) < rpct);
         if (oMsgReady && iMsgValid) nbytes++;
         if (oCoeffValid && iCoeffReady) begin
            check({tag, "_idx"}, oCoeffIdx, xfers);
            check({tag, "_coeff"}, oPolyCoeffs, ref_coeff(xfers));
            if (xfers < N) cap[xfers] = oPolyCoeffs;
            xfers++;
         end
         pv = oCoeffValid; pr = iCoeffReady; pc = oPolyCoeffs; pi = oCoeffIdx;
      end
      check({tag, "_done_count"}, done_cnt, 1);
      check({tag, "_xfers"}, xfers, N);
      check({tag, "_bytes"}, nbytes, NBYTES);
      check({tag, "_idle_after"}, {oBusy, oCoeffValid, oMsgReady}, 0);
      if (exp_cyc > 0) check({tag, "_start_to_done"}, done_cyc, exp_cyc);
      iStart = 1'b0; iMsgValid = 1'b0; iCoeffReady = 1'b0;
   endtask

   task automatic load_msg(input bit rand_msg, input logic [7:0] fill, input logic [7:0] b0);
      for (int i = 0; i < NBYTES; i++) msg[i] = rand_msg ? 8'($urandom) : fill;
      if (!rand_msg) msg[0] = b0;
   endtask

   initial begin
      scen[0] = '{"zeros",  1'b0, 8'h00, 8'h00, 100, 100, 1'b0, 289};
      scen[1] = '{"ones",   1'b0, 8'hff, 8'hff, 100, 100, 1'b0, 289};
      scen[2] = '{"a5",     1'b0, 8'h00, 8'ha5, 100, 100, 1'b0, 289};
      scen[3] = '{"stall",  1'b1, 8'h00, 8'h00,  60,  55, 1'b0,  -1};
      scen[4] = '{"noise",  1'b1, 8'h00, 8'h00, 100,  70, 1'b1,  -1};

      vecs[0] = '{0, 12'd1665}; vecs[1] = '{1, 12'd0};
      vecs[2] = '{2, 12'd1665}; vecs[3] = '{3, 12'd0};
      vecs[4] = '{4, 12'd0};    vecs[5] = '{5, 12'd1665};
      vecs[6] = '{6, 12'd0};    vecs[7] = '{7, 12'd1665};
      vecs[8] = '{8, 12'd0};    vecs[9] = '{255, 12'd0};

      iRstN = 1'b0; iStart = 1'b0; iMsgByte = '0; iMsgValid = 1'b0; iCoeffReady = 1'b0;
      #12;
      check_all_zero("reset_outputs");
      @(negedge iClk);
      iRstN = 1'b1;
      @(negedge iClk);
      check_all_zero("idle_after_reset");

      // Latency: ready one cycle after start, bit 0 one cycle after the byte.
      iStart = 1'b1;
      @(negedge iClk);
      iStart = 1'b0;
      check("lat_ready", {oMsgReady, oBusy, oCoeffValid}, 3'b110);
      iMsgByte = 8'h01; iMsgValid = 1'b1;
      @(negedge iClk);
      iMsgValid = 1'b0;
      check("lat_valid", {oCoeffValid, oMsgReady}, 2'b10);
      check("lat_coeff", oPolyCoeffs, 12'd1665);
      check("lat_idx", oCoeffIdx, 0);
      @(negedge iClk);
      check("lat_hold", {oCoeffValid, oCoeffIdx, oPolyCoeffs}, {1'b1, 8'd0, 12'd1665});
      iRstN = 1'b0;
      @(negedge iClk);
      iRstN = 1'b1;

      for (int s = 0; s < 5; s++) begin
         load_msg(scen[s].rand_msg, scen[s].fill, scen[s].b0);
         run_pass(scen[s].name, scen[s].vpct, scen[s].rpct, scen[s].noise, -1, scen[s].exp_cyc);
         if (s == 2) begin
            for (int v = 0; v < 10; v++)
               check($sformatf("a5_vec_idx%0d", vecs[v].idx), cap[vecs[v].idx], vecs[v].coeff);
         end
      end

      // Abort at coefficient 100, then a clean full pass.
      load_msg(1'b1, 8'h00, 8'h00);
      run_pass("abort", 100, 100, 1'b0, 100, -1);
      @(negedge iClk);
      check_all_zero("post_abort_idle");
      load_msg(1'b1, 8'h00, 8'h00);
      run_pass("clean", 100, 100, 1'b0, -1, 289);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
